// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared MIPS32 pipeline constants, fetch FSM states, IF/ID record.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int                ADDR_W   = 12;
  localparam int                DATA_W   = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } if_state_t;

  // Decode reuses this record as its view of the IF/ID register.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] npc;
  } ifid_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Brief    : Single-entry holding register for a fetched word during a stall.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import mips_pkg::*;
#(
  parameter int SKID_ADDR_W = mips_pkg::ADDR_W,
  parameter int SKID_DATA_W = mips_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   drain,
  input  logic                   clear,
  input  logic [SKID_DATA_W-1:0] in_instr,
  input  logic [SKID_ADDR_W-1:0] in_npc,
  output logic                   full,
  output logic [SKID_DATA_W-1:0] out_instr,
  output logic [SKID_ADDR_W-1:0] out_npc
);

  logic                   full_r;
  logic [SKID_DATA_W-1:0] instr_r;
  logic [SKID_ADDR_W-1:0] npc_r;

  // Clear wins over load so a redirect can never leave a stale word behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r  <= 1'b0;
      instr_r <= '0;
      npc_r   <= '0;
    end else if (clear) begin
      full_r  <= 1'b0;
      instr_r <= '0;
      npc_r   <= '0;
    end else if (load) begin
      full_r  <= 1'b1;
      instr_r <= in_instr;
      npc_r   <= in_npc;
    end else if (drain) begin
      full_r  <= 1'b0;
    end
  end

  assign full      = full_r;
  assign out_instr = instr_r;
  assign out_npc   = npc_r;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : MIPS32 instruction fetch: PC, imem request port, IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter int                ADDR_W   = mips_pkg::ADDR_W,
  parameter int                DATA_W   = mips_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_to_PC,
  output logic [ADDR_W-1:0] npc_addr,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_npc
);

  import mips_pkg::*;

  if_state_t         state;
  logic [ADDR_W-1:0] pc;
  logic              req_r;
  ifid_t             ifid_r;

  logic              slot_free;
  logic              fetch_done;
  logic              skid_load;
  logic              skid_drain;
  logic              skid_full;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_npc;

  assign npc_addr   = pc + ADDR_W'(1);
  assign imem_addr  = pc;
  assign imem_req   = req_r;

  assign slot_free  = !ifid_r.valid || !id_stall;
  assign fetch_done = req_r && imem_ready;
  assign skid_load  = !flush && (state == FETCH) && fetch_done && !slot_free;
  assign skid_drain = !flush && (state == HOLD) && !id_stall;

  fetch_skid_buf #(
    .SKID_ADDR_W (ADDR_W),
    .SKID_DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (flush),
    .in_instr  (imem_rdata),
    .in_npc    (npc_addr),
    .full      (skid_full),
    .out_instr (skid_instr),
    .out_npc   (skid_npc)
  );

  // req_r mirrors (state == FETCH) so the request leaves straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_r  <= 1'b0;
      ifid_r <= '0;
    end else if (flush) begin
      pc           <= addr_to_PC;
      ifid_r.valid <= 1'b0;
      state        <= FETCH;
      req_r        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_r <= 1'b1;
        end
        FETCH: begin
          if (fetch_done) begin
            pc <= addr_to_PC;
            if (slot_free) begin
              ifid_r.valid <= 1'b1;
              ifid_r.instr <= imem_rdata;
              ifid_r.npc   <= npc_addr;
            end else begin
              state <= HOLD;
              req_r <= 1'b0;
            end
          end else if (!id_stall) begin
            ifid_r.valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            ifid_r.valid <= skid_full;
            ifid_r.instr <= skid_instr;
            ifid_r.npc   <= skid_npc;
            state        <= FETCH;
            req_r        <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req_r <= 1'b0;
        end
      endcase
    end
  end

  assign ifid_valid = ifid_r.valid;
  assign ifid_instr = ifid_r.instr;
  assign ifid_npc   = ifid_r.npc;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Self-checking bench for if_fetch_stage (directed table + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr_to_PC;
  logic [11:0] npc_addr;
  logic        flush;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [11:0] ifid_npc;

  int n_chk  = 0;
  int n_fail = 0;

  if_fetch_stage #(
    .ADDR_W   (12),
    .DATA_W   (32),
    .RESET_PC (12'h000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_to_PC (addr_to_PC),
    .npc_addr   (npc_addr),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .id_stall   (id_stall),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_npc   (ifid_npc)
  );

  initial forever #5 clk = ~clk;

  // Memory content: word at address a is a*4.
  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {20'h0, a} << 2;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          stall;
    bit          ready;
    bit          fl;
    logic [11:0] tgt;
    bit          e_req;
    logic [11:0] e_addr;
    bit          e_v;
    logic [31:0] e_instr;
    logic [11:0] e_npc;
  } vec_t;

  vec_t tbl [18];

  // Reference model: a fetcher that is active once started and while no
  // word is parked; parked words sit in a queue of at most one entry.
  typedef struct {
    logic [31:0] instr;
    logic [11:0] npc;
  } word_t;

  bit          m_started;
  logic [11:0] m_pc;
  bit          m_v;
  logic [31:0] m_instr;
  logic [11:0] m_npc;
  word_t       m_skid[$];

  task automatic model_reset();
    m_started = 0;
    m_pc      = 12'h000;
    m_v       = 0;
    m_instr   = '0;
    m_npc     = '0;
    m_skid.delete();
  endtask

  task automatic model_step(input bit st, input bit rdy, input bit fl, input logic [11:0] nxt);
    word_t w;
    bit    active;
    active = m_started && (m_skid.size() == 0);
    if (fl) begin
      m_pc = nxt;
      m_v  = 0;
      m_skid.delete();
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_skid.size() != 0) begin
      if (!st) begin
        w       = m_skid.pop_front();
        m_v     = 1;
        m_instr = w.instr;
        m_npc   = w.npc;
      end
    end else if (active && rdy) begin
      w.instr = mem_word(m_pc);
      w.npc   = 12'((int'(m_pc) + 1) % 4096);
      if (!m_v || !st) begin
        m_v     = 1;
        m_instr = w.instr;
        m_npc   = w.npc;
      end else begin
        m_skid.push_back(w);
      end
      m_pc = nxt;
    end else if (!st) begin
      m_v = 0;
    end
  endtask

  task automatic model_compare();
    chk("rnd_req",      {31'h0, imem_req},   {31'h0, (m_started && m_skid.size() == 0)});
    chk("rnd_addr",     {20'h0, imem_addr},  {20'h0, m_pc});
    chk("rnd_npc_addr", {20'h0, npc_addr},   (int'(m_pc) + 1) % 4096);
    chk("rnd_valid",    {31'h0, ifid_valid}, {31'h0, m_v});
    if (m_v) begin
      chk("rnd_instr", ifid_instr,          m_instr);
      chk("rnd_npc",   {20'h0, ifid_npc},   {20'h0, m_npc});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},      {31'h0, imem_req},   32'h0);
    chk({tag, "_addr"},     {20'h0, imem_addr},  32'h0);
    chk({tag, "_npc_addr"}, {20'h0, npc_addr},   32'h1);
    chk({tag, "_valid"},    {31'h0, ifid_valid}, 32'h0);
    chk({tag, "_instr"},    ifid_instr,          32'h0);
    chk({tag, "_npc"},      {20'h0, ifid_npc},   32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] prev_addr;
    logic [11:0] nxt;
    bit          st, rdy, fl;

    rst_n      = 1'b0;
    flush      = 1'b0;
    id_stall   = 1'b0;
    imem_ready = 1'b0;
    addr_to_PC = 12'h000;

    //           stall rdy fl  tgt       req addr     v  instr        npc
    tbl[0]  = '{0, 1, 0, 12'h000, 1, 12'h000, 0, 32'h0,      12'h000};
    tbl[1]  = '{0, 1, 0, 12'h000, 1, 12'h001, 1, 32'h0,      12'h001};
    tbl[2]  = '{0, 1, 0, 12'h000, 1, 12'h002, 1, 32'h4,      12'h002};
    tbl[3]  = '{0, 1, 0, 12'h000, 1, 12'h003, 1, 32'h8,      12'h003};
    tbl[4]  = '{0, 0, 0, 12'h000, 1, 12'h003, 0, 32'h0,      12'h000};
    tbl[5]  = '{0, 0, 0, 12'h000, 1, 12'h003, 0, 32'h0,      12'h000};
    tbl[6]  = '{0, 1, 0, 12'h000, 1, 12'h004, 1, 32'hC,      12'h004};
    tbl[7]  = '{0, 1, 0, 12'h000, 1, 12'h005, 1, 32'h10,     12'h005};
    tbl[8]  = '{1, 1, 0, 12'h000, 0, 12'h006, 1, 32'h10,     12'h005};
    tbl[9]  = '{1, 1, 0, 12'h000, 0, 12'h006, 1, 32'h10,     12'h005};
    tbl[10] = '{1, 0, 0, 12'h000, 0, 12'h006, 1, 32'h10,     12'h005};
    tbl[11] = '{0, 1, 0, 12'h000, 1, 12'h006, 1, 32'h14,     12'h006};
    tbl[12] = '{0, 1, 0, 12'h000, 1, 12'h007, 1, 32'h18,     12'h007};
    tbl[13] = '{0, 1, 1, 12'h040, 1, 12'h040, 0, 32'h0,      12'h000};
    tbl[14] = '{0, 1, 0, 12'h000, 1, 12'h041, 1, 32'h100,    12'h041};
    tbl[15] = '{1, 0, 1, 12'hFFF, 1, 12'hFFF, 0, 32'h0,      12'h000};
    tbl[16] = '{0, 1, 0, 12'h000, 1, 12'h000, 1, 32'h3FFC,   12'h000};
    tbl[17] = '{1, 1, 0, 12'h000, 0, 12'h001, 1, 32'h3FFC,   12'h000};

    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_req", {31'h0, imem_req}, 32'h0);

    // Directed table; the next-PC mux picks PC+1 unless a branch is taken.
    prev_addr = 12'h000;
    for (int i = 0; i < 18; i++) begin
      id_stall   = tbl[i].stall;
      imem_ready = tbl[i].ready;
      flush      = tbl[i].fl;
      addr_to_PC = tbl[i].fl ? tbl[i].tgt : 12'(prev_addr + 12'h001);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i),      {31'h0, imem_req},   {31'h0, tbl[i].e_req});
      chk($sformatf("v%0d_addr", i),     {20'h0, imem_addr},  {20'h0, tbl[i].e_addr});
      chk($sformatf("v%0d_npc_addr", i), {20'h0, npc_addr},   {20'h0, 12'(tbl[i].e_addr + 12'h001)});
      chk($sformatf("v%0d_valid", i),    {31'h0, ifid_valid}, {31'h0, tbl[i].e_v});
      if (tbl[i].e_v) begin
        chk($sformatf("v%0d_instr", i), ifid_instr,         tbl[i].e_instr);
        chk($sformatf("v%0d_npc", i),   {20'h0, ifid_npc},  {20'h0, tbl[i].e_npc});
      end
      prev_addr = tbl[i].e_addr;
    end

    // Asynchronous reset while parked in HOLD, away from any clock edge.
    id_stall = 1'b1;
    flush    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #3 rst_n = 1'b1;
    id_stall   = 1'b0;
    imem_ready = 1'b1;
    addr_to_PC = 12'h001;
    @(posedge clk);
    #1;
    chk("rst_refetch_req",  {31'h0, imem_req},  32'h1);
    chk("rst_refetch_addr", {20'h0, imem_addr}, 32'h0);
    chk("rst_refetch_v",    {31'h0, ifid_valid}, 32'h0);
    addr_to_PC = 12'h001;
    @(posedge clk);
    #1;
    chk("rst_first_v",     {31'h0, ifid_valid}, 32'h1);
    chk("rst_first_instr", ifid_instr,          32'h0);
    chk("rst_first_npc",   {20'h0, ifid_npc},   32'h1);

    // Randomized traffic against the reference model.
    flush = 1'b0;
    do_reset();
    model_reset();
    model_compare();
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 9) < 3);
      rdy = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 15) == 0);
      if (fl)
        nxt = ($urandom_range(0, 3) == 0) ? 12'(12'hFFD + 12'($urandom_range(0, 2)))
                                          : 12'($urandom_range(0, 4095));
      else
        nxt = 12'(m_pc + 12'h001);
      id_stall   = st;
      imem_ready = rdy;
      flush      = fl;
      addr_to_PC = nxt;
      model_step(st, rdy, fl, nxt);
      @(posedge clk);
      #1;
      model_compare();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
